// File: rtl/alsu_pipe.sv
// Parametrised ALSU with a valid-qualified two-stage pipeline, zero flag,
// sticky error flag and error-driven LED blink.
module alsu_pipe #(
    parameter int    WIDTH          = 4,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    input  logic               err_clr,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               zero,
    output logic               err,
    output logic [LED_W-1:0]   leds
);

    localparam int OW      = 2 * WIDTH;
    localparam bit PRIO_A  = (INPUT_PRIORITY != "B");
    localparam bit USE_CIN = (FULL_ADDER == "ON");

    // Stage 1 capture registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             cin_q, sin_q, dir_q;
    logic             red_a_q, red_b_q, byp_a_q, byp_b_q;

    // Stage 2 result registers
    logic [OW-1:0]    out_q, out_d;
    logic             out_valid_q;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic [OW-1:0]    res;
    logic             res_err;
    logic [WIDTH-1:0] prio_op, red_src;
    logic             cin_eff;

    assign prio_op = PRIO_A ? a_q : b_q;
    assign red_src = (red_a_q && red_b_q) ? prio_op : (red_a_q ? a_q : b_q);
    assign cin_eff = USE_CIN & cin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            sin_q      <= 1'b0;
            dir_q      <= 1'b0;
            red_a_q    <= 1'b0;
            red_b_q    <= 1'b0;
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= opcode;
                cin_q   <= cin;
                sin_q   <= serial_in;
                dir_q   <= direction;
                red_a_q <= red_op_A;
                red_b_q <= red_op_B;
                byp_a_q <= bypass_A;
                byp_b_q <= bypass_B;
            end
        end
    end

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        if (byp_a_q && byp_b_q) begin
            res = OW'(prio_op);
        end else if (byp_a_q) begin
            res = OW'(a_q);
        end else if (byp_b_q) begin
            res = OW'(b_q);
        end else begin
            case (op_q)
                3'd0: begin
                    if (red_a_q || red_b_q) res[0] = &red_src;
                    else                    res    = OW'(a_q & b_q);
                end
                3'd1: begin
                    if (red_a_q || red_b_q) res[0] = ^red_src;
                    else                    res    = OW'(a_q ^ b_q);
                end
                3'd2: res = OW'(a_q) + OW'(b_q) + OW'(cin_eff);
                3'd3: res = OW'(a_q) * OW'(b_q);
                3'd4: res = dir_q ? {out_q[OW-2:0], sin_q} : {sin_q, out_q[OW-1:1]};
                3'd5: res = dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
                default: res_err = 1'b1;
            endcase
            // Reductions are only legal on the logic opcodes
            if (op_q >= 3'd2 && op_q <= 3'd5 && (red_a_q || red_b_q)) res_err = 1'b1;
            if (res_err) res = '0;
        end
    end

    always_comb begin
        out_d  = out_q;
        zero_d = zero_q;
        if (s1_valid_q) begin
            out_d  = res;
            zero_d = (res == '0);
        end
        // A new error outranks a coincident clear
        err_d  = (s1_valid_q && res_err) || (err_q && !err_clr);
        leds_d = err_q ? ~leds_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            leds_q      <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= s1_valid_q;
            zero_q      <= zero_d;
            err_q       <= err_d;
            leds_q      <= leds_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign leds      = leds_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe: a default-configured instance and a
// "B"-priority / half-adder instance driven by the same stimulus.
module tb_alsu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  A, B;
    logic [2:0]  opcode;
    logic        cin, serial_in, direction;
    logic        red_op_A, red_op_B, bypass_A, bypass_B, err_clr;

    logic [7:0]  out, out2;
    logic        out_valid, out_valid2, zero, zero2, err, err2;
    logic [15:0] leds, leds2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .err_clr(err_clr), .out(out), .out_valid(out_valid), .zero(zero), .err(err), .leds(leds)
    );

    alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .err_clr(err_clr), .out(out2), .out_valid(out_valid2), .zero(zero2), .err(err2), .leds(leds2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; A = 0; B = 0; opcode = 0; cin = 0; serial_in = 0; direction = 0;
        red_op_A = 0; red_op_B = 0; bypass_A = 0; bypass_B = 0; err_clr = 0;
    endtask

    // Called at a negedge with fields set; returns at the negedge after the result edge
    task automatic beat();
        in_valid = 1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_zero", zero, 0);
        check("rst_err", err, 0);
        check("rst_leds", leds, 0);

        // MUL 15*15, latency and single-cycle strobe
        opcode = 3; A = 15; B = 15;
        in_valid = 1;
        @(negedge clk);
        idle_inputs();
        check("mul_early_valid", out_valid, 0);
        @(negedge clk);
        check("mul_out", out, 225);
        check("mul_valid", out_valid, 1);
        check("mul_zero", zero, 0);
        check("mul_out2", out2, 225);
        @(negedge clk);
        check("mul_valid_drop", out_valid, 0);
        check("mul_hold", out, 225);

        // ADD with carry-in, full vs half adder
        opcode = 2; A = 7; B = 9; cin = 1;
        beat();
        check("add_full", out, 17);
        check("add_half", out2, 16);

        // Bypass both: priority selection, and bypass masks invalid opcode
        bypass_A = 1; bypass_B = 1; A = 5; B = 10;
        beat();
        check("byp_prioA", out, 5);
        check("byp_prioB", out2, 10);
        bypass_A = 1; bypass_B = 1; A = 5; B = 10; opcode = 7;
        beat();
        check("byp_op7_out", out, 5);
        check("byp_op7_err", err, 0);
        check("byp_op7_err2", err2, 0);

        // XOR reduction with both red_op set
        opcode = 1; red_op_A = 1; red_op_B = 1; A = 4'b0111; B = 4'b0011;
        beat();
        check("xred_prioA", out, 1);
        check("xred_prioB", out2, 0);
        check("xred_zero2", zero2, 1);

        // ADD with red_op_B is an error result
        opcode = 2; red_op_B = 1; A = 3; B = 4;
        beat();
        check("err_out", out, 0);
        check("err_zero", zero, 1);
        check("err_flag", err, 1);
        check("err_leds0", leds, 0);
        @(negedge clk); check("leds_1", leds, 16'hFFFF);
        @(negedge clk); check("leds_2", leds, 16'h0000);
        @(negedge clk); check("leds_3", leds, 16'hFFFF);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("clr_err", err, 0);
        @(negedge clk);
        check("clr_leds", leds, 0);
        check("clr_err2", err2, 0);

        // Clear coincident with a new error result: set wins
        opcode = 6;
        in_valid = 1;
        @(negedge clk);
        idle_inputs();
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("setclr_err", err, 1);
        check("setclr_zero", zero, 1);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("setclr_cleared", err, 0);

        // Shift / rotate on the out register
        bypass_A = 1; A = 1;
        beat();
        check("load_01", out, 8'h01);
        opcode = 4; direction = 1; serial_in = 1;
        beat();
        check("shl_03", out, 8'h03);
        opcode = 5; direction = 0;
        beat();
        check("ror_81", out, 8'h81);
        check("ror_zero", zero, 0);
        opcode = 5; direction = 1;
        beat();
        check("rol_03", out, 8'h03);
        opcode = 4; direction = 0; serial_in = 0;
        beat();
        check("shr_01", out, 8'h01);
        opcode = 4; direction = 0; serial_in = 0;
        beat();
        check("shr_00", out, 8'h00);
        check("shr_zero", zero, 1);
        repeat (3) @(negedge clk);
        check("idle_hold", out, 8'h00);
        check("idle_valid", out_valid, 0);

        // Back-to-back beats: MUL, ADD, AND
        opcode = 3; A = 3; B = 5; in_valid = 1;
        @(negedge clk);
        opcode = 2; A = 2; B = 3; cin = 0; in_valid = 1;
        @(negedge clk);
        opcode = 0; A = 12; B = 10; in_valid = 1;
        check("b2b_mul", out, 15);
        check("b2b_mul_v", out_valid, 1);
        @(negedge clk);
        idle_inputs();
        check("b2b_add", out, 5);
        check("b2b_add_v", out_valid, 1);
        @(negedge clk);
        check("b2b_and", out, 8);
        check("b2b_and_v", out_valid, 1);
        @(negedge clk);
        check("b2b_end_v", out_valid, 0);

        // Reset one cycle after a beat discards it
        opcode = 3; A = 9; B = 9;
        in_valid = 1;
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mrst_valid", out_valid, 0);
        check("mrst_out", out, 0);
        check("mrst_zero", zero, 0);
        check("mrst_err", err, 0);
        check("mrst_leds", leds, 0);
        @(negedge clk);
        check("mrst_valid_after", out_valid, 0);
        check("mrst_out_after", out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
